// File: rtl/fifo_uart_tx_if.sv
// ============================================================================
// Module  : fifo_uart_tx_if
// Brief   : FIFO read-port and UART serial-line signals of the FIFO UART sender.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface fifo_uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  enable;
    logic                  rempty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rd_en;
    logic                  tx;
    logic                  busy;
    logic                  done;

    // master: the transmitter itself; slave: FIFO / line observer side
    modport master (
        input  enable,
        input  rempty,
        input  rdata,
        output rd_en,
        output tx,
        output busy,
        output done
    );

    modport slave (
        output enable,
        output rempty,
        output rdata,
        input  rd_en,
        input  tx,
        input  busy,
        input  done
    );
endinterface

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module  : fifo_uart_tx
// Brief   : Pops words from a fall-through FIFO read port and sends each as a
//           UART frame (start, LSB-first data, optional parity, 1-2 stop bits).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  wire logic      i_clk,
    input  wire logic      i_rst,
    fifo_uart_tx_if.master bus
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [c_BAUD_W-1:0]   r_baud;
    logic [c_BIT_W-1:0]    r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par;
    logic                  r_tx;

    state_t                w_state_next;
    logic [c_BAUD_W-1:0]   w_baud_next;
    logic [c_BIT_W-1:0]    w_bit_next;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_par_next;
    logic                  w_tx_next;

    logic                  w_bit_end;
    logic                  w_last_stop;
    logic                  w_take;
    logic                  w_word_parity;

    assign w_bit_end     = (r_baud == c_BAUD_LAST);
    assign w_last_stop   = (r_state == ST_STOP) && w_bit_end && (r_bit == c_STOP_LAST);
    assign w_take        = !i_rst && bus.enable && !bus.rempty &&
                           ((r_state == ST_IDLE) || w_last_stop);
    assign w_word_parity = (PARITY == 2) ? ~^bus.rdata : ^bus.rdata;

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        w_tx_next    = r_tx;

        if (r_state != ST_IDLE) begin
            w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
        end

        // r_tx is loaded with the level of the bit that starts next cycle
        case (r_state)
            ST_IDLE: begin
                w_tx_next   = 1'b1;
                w_baud_next = '0;
                w_bit_next  = '0;
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                    w_bit_next   = '0;
                    w_tx_next    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == c_DATA_LAST) begin
                        w_bit_next = '0;
                        if (PARITY != 0) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_par;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_next   = r_bit + 1'b1;
                        w_shift_next = r_shift >> 1;
                        w_tx_next    = w_shift_next[0];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                    w_bit_next   = '0;
                    w_tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_bit == c_STOP_LAST) begin
                        w_state_next = ST_IDLE;
                        w_bit_next   = '0;
                    end else begin
                        w_bit_next   = r_bit + 1'b1;
                    end
                    w_tx_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_baud_next  = '0;
                w_bit_next   = '0;
                w_tx_next    = 1'b1;
            end
        endcase

        // A pop overrides the stop-to-idle path, giving gap-free streaming
        if (w_take) begin
            w_state_next = ST_START;
            w_shift_next = bus.rdata;
            w_par_next   = w_word_parity;
            w_baud_next  = '0;
            w_bit_next   = '0;
            w_tx_next    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_par   <= w_par_next;
            r_tx    <= w_tx_next;
        end
    end

    assign bus.rd_en = w_take;
    assign bus.tx    = r_tx;
    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.done  = w_last_stop;

endmodule

`default_nettype wire
